// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the cpu memory loader: FSM states,
// bytes-per-word for each memory and the default memory depths.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_OUT,
    FIN
  } loader_state_t;

  localparam int IMEM_BYTES_PER_WORD = 4;
  localparam int DMEM_BYTES_PER_WORD = 8;

  localparam int DEFAULT_IMEM_WORDS = 512;
  localparam int DEFAULT_DMEM_WORDS = 1024;
  localparam int DEFAULT_CNT_W      = 11;
  localparam int DEFAULT_RUN_W      = 32;

endpackage

// File: rtl/loader_word_counter.sv
// Up-counter with a loadable limit, clear, increment-on-strobe and flags for
// "count equals limit" (tc) and "next increment reaches limit" (last).
module loader_word_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] limit_in,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         last
);

  logic [W-1:0] limit_q;

  // clear takes priority so a phase change can reset the index on its final increment
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count   <= '0;
      limit_q <= '0;
    end else begin
      if (load)
        limit_q <= limit_in;
      if (clear)
        count <= '0;
      else if (inc)
        count <= count + 1'b1;
    end
  end

  assign tc   = (count == limit_q);
  assign last = (({1'b0, count} + (W+1)'(1)) == {1'b0, limit_q});

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side loader: streams a program into imem then dmem, runs the cpu for a
// set number of cycles, then dumps a dmem window. Option: LOADER_CHECKSUM_EN.
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_WORDS = DEFAULT_IMEM_WORDS,
  parameter int DMEM_WORDS = DEFAULT_DMEM_WORDS,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int RUN_W      = DEFAULT_RUN_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_len,
  input  logic [CNT_W-1:0] dmem_len,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_len,
  input  logic             s_valid,
  input  logic [63:0]      s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [63:0]      m_data,
  input  logic             m_ready,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  input  logic [31:0]      rdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             cpu_enable,
  output logic             busy,
`ifdef LOADER_CHECKSUM_EN
  output logic             done,
  output logic [31:0]      load_sum
`else
  output logic             done
`endif
);

  localparam logic [CNT_W-1:0] IMEM_MAX = CNT_W'(IMEM_WORDS);
  localparam logic [CNT_W-1:0] DMEM_MAX = CNT_W'(DMEM_WORDS);

  loader_state_t    state, state_nxt;
  logic [CNT_W-1:0] imem_len_sat, dmem_len_sat, dump_len_sat;
  logic [CNT_W-1:0] dmem_len_q, dump_len_q;
  logic             accept_start;

  logic             idx_clear, idx_load, idx_inc, idx_tc, idx_last;
  logic [CNT_W-1:0] idx, idx_limit;
  logic [63:0]      idx_wide;

  logic             run_tc, unused_run_last;
  logic [RUN_W-1:0] unused_run_count;
  logic             unused_rdata;

  assign imem_len_sat = (imem_len > IMEM_MAX) ? IMEM_MAX : imem_len;
  assign dmem_len_sat = (dmem_len > DMEM_MAX) ? DMEM_MAX : dmem_len;
  assign dump_len_sat = (dump_len > DMEM_MAX) ? DMEM_MAX : dump_len;
  assign accept_start = (state == IDLE) && start;
  assign unused_rdata = ^rdata_ext;

  loader_word_counter #(.W(CNT_W)) u_idx (
    .clk      (clk),
    .arst     (arst),
    .clear    (idx_clear),
    .load     (idx_load),
    .limit_in (idx_limit),
    .inc      (idx_inc),
    .count    (idx),
    .tc       (idx_tc),
    .last     (idx_last)
  );

  loader_word_counter #(.W(RUN_W)) u_run (
    .clk      (clk),
    .arst     (arst),
    .clear    (accept_start),
    .load     (accept_start),
    .limit_in (run_cycles),
    .inc      (cpu_enable),
    .count    (unused_run_count),
    .tc       (run_tc),
    .last     (unused_run_last)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      dmem_len_q <= '0;
      dump_len_q <= '0;
      m_data     <= '0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        dmem_len_q <= dmem_len_sat;
        dump_len_q <= dump_len_sat;
      end
      if (state == DUMP_WAIT)
        m_data <= rdata_ext_2;
    end
  end

  // Each phase exit clears the index and loads the limit for the next phase,
  // so a zero-length phase is seen as tc on its first cycle.
  always_comb begin
    state_nxt  = state;
    idx_clear  = 1'b0;
    idx_load   = 1'b0;
    idx_limit  = imem_len_sat;
    idx_inc    = 1'b0;
    s_ready    = 1'b0;
    wen_ext    = 1'b0;
    wen_ext_2  = 1'b0;
    ren_ext_2  = 1'b0;
    m_valid    = 1'b0;
    cpu_enable = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_I;
          idx_clear = 1'b1;
          idx_load  = 1'b1;
          idx_limit = imem_len_sat;
        end
      end
      LOAD_I: begin
        idx_limit = dmem_len_q;
        if (idx_tc) begin
          state_nxt = LOAD_D;
          idx_clear = 1'b1;
          idx_load  = 1'b1;
        end else begin
          s_ready = 1'b1;
          wen_ext = s_valid;
          idx_inc = s_valid;
          if (s_valid && idx_last) begin
            state_nxt = LOAD_D;
            idx_clear = 1'b1;
            idx_load  = 1'b1;
          end
        end
      end
      LOAD_D: begin
        idx_limit = dump_len_q;
        if (idx_tc) begin
          state_nxt = RUN;
          idx_clear = 1'b1;
          idx_load  = 1'b1;
        end else begin
          s_ready   = 1'b1;
          wen_ext_2 = s_valid;
          idx_inc   = s_valid;
          if (s_valid && idx_last) begin
            state_nxt = RUN;
            idx_clear = 1'b1;
            idx_load  = 1'b1;
          end
        end
      end
      RUN: begin
        if (run_tc)
          state_nxt = idx_tc ? FIN : DUMP_RD;
        else
          cpu_enable = 1'b1;
      end
      DUMP_RD: begin
        ren_ext_2 = 1'b1;
        state_nxt = DUMP_WAIT;
      end
      DUMP_WAIT: state_nxt = DUMP_OUT;
      DUMP_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          idx_inc   = 1'b1;
          state_nxt = idx_last ? FIN : DUMP_RD;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idx_wide    = 64'(idx);
  assign busy        = (state != IDLE);
  assign ren_ext     = 1'b0;
  assign addr_ext    = wen_ext ? idx_wide * 64'(IMEM_BYTES_PER_WORD) : '0;
  assign wdata_ext   = wen_ext ? s_data[31:0] : '0;
  assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? idx_wide * 64'(DMEM_BYTES_PER_WORD) : '0;
  assign wdata_ext_2 = wen_ext_2 ? s_data : '0;

`ifdef LOADER_CHECKSUM_EN
  // Running sum of accepted words; only changes on load strobes, so it holds after LOAD_D.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      load_sum <= '0;
    else if (accept_start)
      load_sum <= '0;
    else if (wen_ext)
      load_sum <= load_sum + s_data[31:0];
    else if (wen_ext_2)
      load_sum <= load_sum + s_data[31:0] + s_data[63:32];
  end
`endif

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Randomized self-checking bench for cpu_mem_loader with a dmem SRAM model and
// a stream-level reference model. Define LOADER_CHECKSUM_EN to check load_sum.
module tb_cpu_mem_loader;

  localparam int IMEM_WORDS = 512;
  localparam int DMEM_WORDS = 1024;
  localparam int CNT_W      = 11;
  localparam int RUN_W      = 32;

  logic             clk, arst, start;
  logic [CNT_W-1:0] imem_len, dmem_len, dump_len;
  logic [RUN_W-1:0] run_cycles;
  logic             s_valid, s_ready, m_valid, m_ready;
  logic [63:0]      s_data, m_data;
  logic [63:0]      addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]      wdata_ext, rdata_ext;
  logic             cpu_enable, busy, done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      load_sum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] ref_dmem [DMEM_WORDS];
  logic [63:0] sram_d   [DMEM_WORDS];
  bit          sram_wr  [DMEM_WORDS];
  logic [63:0] dir_words [$];

  cpu_mem_loader #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .CNT_W      (CNT_W),
    .RUN_W      (RUN_W)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .imem_len    (imem_len),
    .dmem_len    (dmem_len),
    .run_cycles  (run_cycles),
    .dump_len    (dump_len),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
`ifdef LOADER_CHECKSUM_EN
    .done        (done),
    .load_sum    (load_sum)
`else
    .done        (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int k);
    return {32'hC0DE_0000 | 32'(k), 32'(k) * 32'h9E37_79B9};
  endfunction

  // Data SRAM with one-cycle read latency; unwritten words read their initial pattern.
  always @(posedge clk) begin
    if (wen_ext_2) begin
      sram_d[addr_ext_2[12:3]]  <= wdata_ext_2;
      sram_wr[addr_ext_2[12:3]] <= 1'b1;
    end
    if (ren_ext_2)
      rdata_ext_2 <= sram_wr[addr_ext_2[12:3]] ? sram_d[addr_ext_2[12:3]]
                                               : init_word(int'(addr_ext_2[12:3]));
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_data", m_data, 64'd0);
    checkOutput("rst_addr_ext", addr_ext, 64'd0);
    checkOutput("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
    checkOutput("rst_wdata_ext", 64'(wdata_ext), 64'd0);
    checkOutput("rst_addr_ext_2", addr_ext_2, 64'd0);
    checkOutput("rst_wdata_ext_2", wdata_ext_2, 64'd0);
    checkOutput("rst_ctrl", 64'({cpu_enable, busy, done}), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("rst_load_sum", 64'(load_sum), 64'd0);
`endif
  endtask

  // One full load/run/dump sequence checked against the stream-level model.
  task automatic applyStimulus(input int i_len, input int d_len, input int r_cyc, input int du_len,
                               input int valid_pct, input int ready_pct, input int stall_first);
    int          i_sat, d_sat, du_sat, total, n_acc, nr, nout, n_en, n_done, cycles, budget, stalls;
    logic [63:0] word_q [$];
    logic [63:0] w, prev_m, last_i_addr;
    logic        prev_stall, prev_en, hs;
    logic [31:0] sum_ref;
    i_sat  = (i_len > IMEM_WORDS) ? IMEM_WORDS : i_len;
    d_sat  = (d_len > DMEM_WORDS) ? DMEM_WORDS : d_len;
    du_sat = (du_len > DMEM_WORDS) ? DMEM_WORDS : du_len;
    total  = i_sat + d_sat;
    sum_ref = '0;
    for (int j = 0; j < total; j++) begin
      if (dir_words.size() > 0) w = dir_words.pop_front();
      else w = {$urandom(), $urandom()};
      word_q.push_back(w);
      if (j < i_sat) sum_ref += w[31:0];
      else begin
        sum_ref += w[31:0] + w[63:32];
        ref_dmem[j - i_sat] = w;
      end
    end
    n_acc = 0; nr = 0; nout = 0; n_en = 0; n_done = 0; cycles = 0; stalls = 0;
    prev_stall = 1'b0; prev_en = 1'b0; prev_m = '0; last_i_addr = '0;
    budget = 20 * (total + du_sat) + r_cyc + stall_first + 50;

    @(negedge clk);
    imem_len   = CNT_W'(i_len);
    dmem_len   = CNT_W'(d_len);
    dump_len   = CNT_W'(du_len);
    run_cycles = RUN_W'(r_cyc);
    start      = 1'b1;
    s_valid    = 1'b0;
    m_ready    = 1'b0;
    @(negedge clk);

    while (n_done == 0 && cycles < budget) begin
      start      = ($urandom_range(15) == 0);
      imem_len   = CNT_W'($urandom());
      dmem_len   = CNT_W'($urandom());
      dump_len   = CNT_W'($urandom());
      run_cycles = $urandom();
      if (valid_pct < 0) s_valid = cycles[0];
      else s_valid = ($urandom_range(99) < valid_pct);
      s_data = (word_q.size() > 0) ? word_q[0] : {$urandom(), $urandom()};
      if (m_valid && nout == 0 && stalls < stall_first) begin
        m_ready = 1'b0;
        stalls++;
      end else begin
        m_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      hs = s_valid && s_ready;
      checkOutput("busy", 64'(busy), 64'd1);
      checkOutput("ren_ext", 64'(ren_ext), 64'd0);
      checkOutput("s_ready_idle", 64'(s_ready && n_acc >= total), 64'd0);
      checkOutput("wen_ext", 64'(wen_ext), 64'(hs && n_acc < i_sat));
      checkOutput("wen_ext_2", 64'(wen_ext_2), 64'(hs && n_acc >= i_sat && n_acc < total));
      if (hs && n_acc < i_sat) begin
        checkOutput("addr_ext", addr_ext, 64'(n_acc) * 64'd4);
        checkOutput("wdata_ext", 64'(wdata_ext), 64'(word_q[0][31:0]));
        last_i_addr = addr_ext;
      end else if (hs && n_acc < total) begin
        checkOutput("addr_ext_2_wr", addr_ext_2, 64'(n_acc - i_sat) * 64'd8);
        checkOutput("wdata_ext_2", wdata_ext_2, word_q[0]);
      end
      if (hs && n_acc < total) begin
        void'(word_q.pop_front());
        n_acc++;
      end
      if (cpu_enable) begin
        checkOutput("enable_strobes", 64'({wen_ext, wen_ext_2, ren_ext_2}), 64'd0);
        checkOutput("enable_after_load", 64'(n_acc), 64'(total));
        checkOutput("enable_contiguous", 64'(prev_en || n_en == 0), 64'd1);
        n_en++;
      end
      prev_en = cpu_enable;
      checkOutput("wen_ren_excl", 64'(wen_ext_2 && ren_ext_2), 64'd0);
      if (ren_ext_2) begin
        checkOutput("dump_after_run", 64'(n_en), 64'(r_cyc));
        checkOutput("dump_rd_count", 64'(nr < du_sat), 64'd1);
        checkOutput("addr_ext_2_rd", addr_ext_2, 64'(nr) * 64'd8);
        nr++;
      end
      if (m_valid) begin
        if (prev_stall) checkOutput("m_data_stable", m_data, prev_m);
        if (m_ready) begin
          checkOutput("dump_count", 64'(nout < du_sat), 64'd1);
          if (nout < du_sat) checkOutput("m_data", m_data, ref_dmem[nout]);
          nout++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_m     = m_data;
      if (done) begin
        n_done++;
        checkOutput("done_words", 64'(n_acc), 64'(total));
        checkOutput("done_enable_cycles", 64'(n_en), 64'(r_cyc));
        checkOutput("done_reads", 64'(nr), 64'(du_sat));
        checkOutput("done_dumps", 64'(nout), 64'(du_sat));
        if (i_sat > 0) checkOutput("last_imem_addr", last_i_addr, 64'(i_sat - 1) * 64'd4);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("load_sum", 64'(load_sum), 64'(sum_ref));
`endif
      end
      cycles++;
      @(negedge clk);
    end
    checkOutput("done_within_budget", 64'(n_done), 64'd1);
    start   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [63:0] abort_word;
    for (int k = 0; k < DMEM_WORDS; k++) ref_dmem[k] = init_word(k);
    arst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0;
    rdata_ext = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    arst = 1'b0;

    $display("[TB] three instruction words, s_valid held high");
    dir_words = '{64'h0000_0000_0000_0013, 64'h0000_0000_0010_0093, 64'h0000_0000_0020_8113};
    applyStimulus(3, 0, 0, 0, 100, 100, 0);

    $display("[TB] two data words, s_valid toggling");
    dir_words = '{64'hAAAA_0000_0000_0001, 64'h0000_0000_0000_0005};
    applyStimulus(0, 2, 0, 0, -1, 100, 0);

    $display("[TB] run for five cycles");
    applyStimulus(0, 0, 5, 0, 100, 100, 0);

    $display("[TB] dump two words with first word stalled");
    dir_words = '{64'h11, 64'h22};
    applyStimulus(0, 2, 0, 2, 100, 100, 4);

    $display("[TB] reset during data load");
    @(negedge clk);
    imem_len = '0; dmem_len = CNT_W'(4); dump_len = '0; run_cycles = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort_word = 64'hDEAD_BEEF_0BAD_F00D;
    s_valid = 1'b1;
    s_data  = abort_word;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      #1;
      if (wen_ext_2) begin
        seen = 1'b1;
        checkOutput("abort_first_addr", addr_ext_2, 64'd0);
      end
      @(negedge clk);
    end
    checkOutput("abort_saw_write", 64'(seen), 64'd1);
    ref_dmem[0] = abort_word;
    arst = 1'b1;
    #1;
    checkResetState();
    @(negedge clk);
    arst = 1'b0;
    s_valid = 1'b0;
    applyStimulus(2, 1, 3, 2, 70, 70, 0);

    $display("[TB] oversized imem and dump lengths saturate");
    applyStimulus(600, 3, 2, 1500, 90, 80, 0);

    $display("[TB] random sequences");
    for (int t = 0; t < 8; t++)
      applyStimulus($urandom_range(24), $urandom_range(24), $urandom_range(20), $urandom_range(24),
                    $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
